// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IFU,
        OWN_LSU
    } owner_e;

    localparam int MEM_DATA_W = 32;
    localparam int WORD_BYTES = 4;
    localparam int OFFS_W     = $clog2(WORD_BYTES);
    localparam int STRB_W     = MEM_DATA_W / 8;

endpackage

// File: rtl/mem_rsp_slot.sv
// rtl/mem_rsp_slot.sv - one-entry read response holding slot with in-flight tracking
module mem_rsp_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_issue,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_rsp_ready,
    output logic              o_eligible,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data
);

    logic              r_inflight;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Capture wins over release so a freed slot can be refilled in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
        end else begin
            r_inflight <= i_issue;
            if (r_inflight) begin
                r_valid <= 1'b1;
                r_data  <= i_rdata;
            end else if (r_valid && i_rsp_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_eligible  = !r_inflight && (!r_valid || i_rsp_ready);
    assign o_rsp_valid = r_valid;
    assign o_rsp_data  = r_data;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between IFU reads and LSU loads/stores
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DATA_W-1:0] ifu_rsp_data,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_write,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [STRB_W-1:0] lsu_req_wstrb,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DATA_W-1:0] lsu_rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_LSU_STREAK + 1);

    logic                w_ifu_elig;
    logic                w_lsu_load_elig;
    logic                w_ifu_ok;
    logic                w_lsu_ok;
    logic                w_ifu_issue;
    logic                w_lsu_issue;
    logic                w_unused_offs;
    owner_e              w_owner;
    logic [STREAK_W-1:0] r_streak;

    assign w_ifu_ok = !rst && ifu_req_valid && w_ifu_elig;
    assign w_lsu_ok = !rst && lsu_req_valid && (lsu_req_write || w_lsu_load_elig);

    always_comb begin
        w_owner = OWN_NONE;
        if (w_ifu_ok && w_lsu_ok) begin
            w_owner = (r_streak == STREAK_W'(MAX_LSU_STREAK)) ? OWN_IFU : OWN_LSU;
        end else if (w_ifu_ok) begin
            w_owner = OWN_IFU;
        end else if (w_lsu_ok) begin
            w_owner = OWN_LSU;
        end
    end

    assign ifu_req_ready = (w_owner == OWN_IFU);
    assign lsu_req_ready = (w_owner == OWN_LSU);
    assign w_ifu_issue   = ifu_req_ready;
    assign w_lsu_issue   = lsu_req_ready && !lsu_req_write;

    always_comb begin
        mem_en    = (w_owner != OWN_NONE);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (w_owner == OWN_IFU) begin
            mem_addr = ifu_req_addr[ADDR_W-1:OFFS_W];
        end else if (w_owner == OWN_LSU) begin
            mem_addr = lsu_req_addr[ADDR_W-1:OFFS_W];
            if (lsu_req_write) begin
                mem_we    = 1'b1;
                mem_wdata = lsu_req_wdata;
                mem_wstrb = lsu_req_wstrb;
            end
        end
    end

    // Byte offsets are dropped: accesses are word-aligned by truncation.
    assign w_unused_offs = ^{ifu_req_addr[OFFS_W-1:0], lsu_req_addr[OFFS_W-1:0]};

    // Streak only counts LSU wins while IFU is actually waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= '0;
        end else if (!ifu_req_valid || w_owner == OWN_IFU) begin
            r_streak <= '0;
        end else if (w_owner == OWN_LSU && r_streak != STREAK_W'(MAX_LSU_STREAK)) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    mem_rsp_slot #(.DATA_W(DATA_W)) u_ifu_slot (
        .clk         (clk),
        .rst         (rst),
        .i_issue     (w_ifu_issue),
        .i_rdata     (mem_rdata),
        .i_rsp_ready (ifu_rsp_ready),
        .o_eligible  (w_ifu_elig),
        .o_rsp_valid (ifu_rsp_valid),
        .o_rsp_data  (ifu_rsp_data)
    );

    mem_rsp_slot #(.DATA_W(DATA_W)) u_lsu_slot (
        .clk         (clk),
        .rst         (rst),
        .i_issue     (w_lsu_issue),
        .i_rdata     (mem_rdata),
        .i_rsp_ready (lsu_rsp_ready),
        .o_eligible  (w_lsu_load_elig),
        .o_rsp_valid (lsu_rsp_valid),
        .o_rsp_data  (lsu_rsp_data)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and random checks of mem_port_arbiter against a reference model
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_write;
    logic [31:0] lsu_req_addr;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;
    logic        lsu_rsp_valid;
    logic        lsu_rsp_ready;
    logic [31:0] lsu_rsp_data;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: read pending last cycle, held response, LSU-wins-while-IFU-waits count
    bit          m_ifu_busy, m_lsu_busy, m_ifu_hold, m_lsu_hold;
    logic [31:0] m_ifu_data, m_lsu_data;
    int          m_streak;
    int          last_own;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LSU_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_write(lsu_req_write),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ifu_busy = 0; m_lsu_busy = 0; m_ifu_hold = 0; m_lsu_hold = 0;
        m_ifu_data = '0; m_lsu_data = '0; m_streak = 0;
    endtask

    // One clock: predict the grant, check combinational outputs, advance model, check responses.
    task automatic cycle();
        bit ie, le;
        int own;
        ie = !rst && ifu_req_valid && !m_ifu_busy && (!m_ifu_hold || ifu_rsp_ready);
        le = !rst && lsu_req_valid && (lsu_req_write || (!m_lsu_busy && (!m_lsu_hold || lsu_rsp_ready)));
        if (ie && le)  own = (m_streak == MAXS) ? 1 : 2;
        else if (ie)   own = 1;
        else if (le)   own = 2;
        else           own = 0;
        last_own = own;
        #1;
        check("ifu_req_ready", ifu_req_ready, own == 1);
        check("lsu_req_ready", lsu_req_ready, own == 2);
        check("mem_en", mem_en, own != 0);
        check("mem_we", mem_we, own == 2 && lsu_req_write);
        if (own == 1) check("mem_addr_ifu", mem_addr, ifu_req_addr / 4);
        if (own == 2) check("mem_addr_lsu", mem_addr, lsu_req_addr / 4);
        check("mem_wdata", mem_wdata, (own == 2 && lsu_req_write) ? lsu_req_wdata : 32'h0);
        check("mem_wstrb", mem_wstrb, (own == 2 && lsu_req_write) ? lsu_req_wstrb : 4'h0);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_ifu_busy) begin m_ifu_hold = 1; m_ifu_data = mem_rdata; end
            else if (m_ifu_hold && ifu_rsp_ready) m_ifu_hold = 0;
            if (m_lsu_busy) begin m_lsu_hold = 1; m_lsu_data = mem_rdata; end
            else if (m_lsu_hold && lsu_rsp_ready) m_lsu_hold = 0;
            m_ifu_busy = (own == 1);
            m_lsu_busy = (own == 2) && !lsu_req_write;
            if (!ifu_req_valid || own == 1) m_streak = 0;
            else if (own == 2 && m_streak < MAXS) m_streak++;
        end
        #1;
        check("ifu_rsp_valid", ifu_rsp_valid, m_ifu_hold);
        check("ifu_rsp_data", ifu_rsp_data, m_ifu_data);
        check("lsu_rsp_valid", lsu_rsp_valid, m_lsu_hold);
        check("lsu_rsp_data", lsu_rsp_data, m_lsu_data);
    endtask

    initial begin
        int exp_own [6];
        exp_own = '{2, 2, 2, 2, 1, 2};
        rst = 1;
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_rsp_ready = 0;
        lsu_req_valid = 1; lsu_req_write = 0; lsu_req_addr = 32'h10;
        lsu_req_wdata = 0; lsu_req_wstrb = 0; lsu_rsp_ready = 0; mem_rdata = 0;
        model_reset();
        last_own = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_lsu_req_ready", lsu_req_ready, 0);
        check("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
        check("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
        check("rst_ifu_rsp_data", ifu_rsp_data, 0);
        check("rst_lsu_rsp_data", lsu_rsp_data, 0);

        // reset in the middle of an LSU load discards it
        rst = 0;
        #1 check("midrst_grant", lsu_req_ready, 1);
        cycle();
        lsu_req_valid = 0; rst = 1; mem_rdata = 32'hBAD0BAD0;
        #1 check("midrst_mem_en", mem_en, 0);
        cycle();
        rst = 0;
        cycle();
        check("midrst_no_rsp", lsu_rsp_valid, 0);

        // IFU alone
        ifu_req_valid = 1; ifu_req_addr = 32'h104; ifu_rsp_ready = 0;
        #1 check("ifu_mem_addr", mem_addr, 30'h41);
        cycle();
        ifu_req_addr = 32'h108; mem_rdata = 32'hDEADBEEF;
        #1 check("ifu_inflight_block", ifu_req_ready, 0);
        cycle();
        check("ifu_rsp_valid_1", ifu_rsp_valid, 1);
        check("ifu_rsp_data_1", ifu_rsp_data, 32'hDEADBEEF);
        mem_rdata = 32'h0;
        #1 check("ifu_slot_full_block", ifu_req_ready, 0);
        cycle();
        ifu_rsp_ready = 1;
        #1 check("ifu_slot_free_accept", ifu_req_ready, 1);
        cycle();
        ifu_req_valid = 0; mem_rdata = 32'h0000_1108;
        cycle();
        cycle();

        // LSU back-to-back stores
        lsu_req_valid = 1; lsu_req_write = 1; lsu_req_addr = 32'h22;
        lsu_req_wdata = 32'h00AB0000; lsu_req_wstrb = 4'b0100;
        #1;
        check("st_mem_we", mem_we, 1);
        check("st_mem_addr", mem_addr, 30'h8);
        check("st_mem_wstrb", mem_wstrb, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            #1 check("st_b2b_ready", lsu_req_ready, 1);
            cycle();
            check("st_no_rsp", lsu_rsp_valid, 0);
        end
        lsu_req_valid = 0;
        cycle();

        // contention: streak guard lets IFU through after four LSU wins
        ifu_req_valid = 1; ifu_req_addr = 32'h200; ifu_rsp_ready = 1;
        lsu_req_valid = 1; lsu_req_write = 1; lsu_req_addr = 32'h300;
        for (int k = 0; k < 6; k++) begin
            #1 check("contention_owner", {ifu_req_ready, lsu_req_ready},
                     (exp_own[k] == 1) ? 2'b10 : 2'b01);
            cycle();
            if (last_own == 1) ifu_req_addr = 32'h204;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        cycle();
        cycle();

        // LSU load response backpressure
        lsu_req_valid = 1; lsu_req_write = 0; lsu_req_addr = 32'h40; lsu_rsp_ready = 0;
        cycle();
        lsu_req_addr = 32'h44; mem_rdata = 32'h12345678;
        cycle();
        for (int i = 0; i < 5; i++) begin
            mem_rdata = $urandom();
            #1 check("bp_load_blocked", lsu_req_ready, 0);
            cycle();
            check("bp_hold_valid", lsu_rsp_valid, 1);
            check("bp_hold_data", lsu_rsp_data, 32'h12345678);
        end
        lsu_rsp_ready = 1;
        #1 check("bp_release_accept", lsu_req_ready, 1);
        cycle();
        lsu_req_valid = 0; mem_rdata = 32'h0000_0044;
        cycle();
        cycle();

        // alternating IFU/LSU loads keep the port busy every cycle
        ifu_req_valid = 1; ifu_req_addr = 32'h400; ifu_rsp_ready = 1;
        lsu_req_valid = 1; lsu_req_write = 0; lsu_req_addr = 32'h800; lsu_rsp_ready = 1;
        for (int i = 0; i < 8; i++) begin
            mem_rdata = 32'hA000_0000 + i;
            #1 check("alt_mem_en", mem_en, 1);
            cycle();
            if (last_own == 1) ifu_req_addr = ifu_req_addr + 4;
            if (last_own == 2) lsu_req_addr = lsu_req_addr + 4;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        cycle();
        cycle();

        // random traffic; payload only changes when idle or just accepted
        for (int i = 0; i < 400; i++) begin
            bit ifu_free, lsu_free;
            ifu_free = !ifu_req_valid || last_own == 1;
            lsu_free = !lsu_req_valid || last_own == 2;
            if (ifu_free) begin
                ifu_req_valid = ($urandom_range(0, 3) != 0);
                ifu_req_addr  = $urandom();
            end
            if (lsu_free) begin
                lsu_req_valid = ($urandom_range(0, 2) != 0);
                lsu_req_write = $urandom_range(0, 1);
                lsu_req_addr  = $urandom();
                lsu_req_wdata = $urandom();
                lsu_req_wstrb = 4'($urandom_range(0, 15));
            end
            ifu_rsp_ready = ($urandom_range(0, 3) != 0);
            lsu_rsp_ready = ($urandom_range(0, 3) != 0);
            mem_rdata     = $urandom();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
